gcd_operand_loader: RTL and testbench
=====================================

# gcd_operand_loader

Upstream input stage for the GCD datapath on the C5GX board. It debounces a push-button, captures two unsigned operands from the slide switches on successive presses, and issues a one-cycle `start` to the GCD core. It then waits for the core's `done`, latches the result for the LEDs, and returns to operand entry on the next press. Zero operands are rejected before the core is started.

## Interface
Parameters:
- `WIDTH`, 8, operand and result width; switch values are unsigned.
- `DEBOUNCE_CYCLES`, 16, consecutive stable synchronized cycles needed to accept a button level change. Minimum 2; board build overrides with 1250000.

Ports:
- `CLOCK_125_p`, in, 1, single system clock; all state is on its rising edge.
- `rst`, in, 1, asynchronous active-low reset.
- `sw`, in, WIDTH, operand switches; sampled only on an accepted press.
- `key_n`, in, 1, raw push-button; asynchronous, active-low (0 = pressed).
- `start`, out, 1, one-cycle pulse to the GCD core.
- `a_out`, out, WIDTH, operand A to the core; held stable from `start` until the next reset or IDLE_A entry.
- `b_out`, out, WIDTH, operand B to the core; same stability rule as `a_out`.
- `done`, in, 1, core completion; level or pulse, sampled only in BUSY.
- `result`, in, WIDTH, core result; valid in the cycle `done`=1.
- `result_out`, out, WIDTH, latched GCD result for the LEDs.
- `result_valid`, out, 1, high in SHOW.
- `err`, out, 1, high in ERR (an operand was zero).
- `phase`, out, 2, LED status: 00 = IDLE_A, 01 = WAIT_B, 10 = START or BUSY, 11 = SHOW or ERR.

## Operation
Button path:
- `key_n` passes through a 2-flop synchronizer. The debounced level resets to 1 (released) and the debounce counter to 0.
- Each cycle the synchronized value differs from the debounced level, the counter increments. When it equals the debounced level, the counter clears.
- After DEBOUNCE_CYCLES consecutive differing cycles, the debounced level flips and the counter clears.
- `press` is a registered one-cycle pulse asserted on the cycle after a debounced 1->0 transition. A release never generates an event.

FSM:
- IDLE_A: on `press`, A <= `sw`; go to WAIT_B.
- WAIT_B: on `press`, B <= `sw`. If A==0 or the sampled `sw`==0, go to ERR; otherwise go to START.
- START: `start`=1 for exactly this cycle; go to BUSY unconditionally.
- BUSY: on the first cycle `done`=1, `result_out` <= `result`; go to SHOW. A `press` here is ignored.
- SHOW: hold `result_out`; on `press`, go to IDLE_A.
- ERR: on `press`, go to IDLE_A.
- Entry to IDLE_A: clears A, B, `result_out`, `err`, `result_valid`.
- `done` outside BUSY is ignored, and `start` is never reissued without two new presses.
- Reset, including mid-BUSY: every output 0, state IDLE_A, synchronizer flops 1, debounced level 1, counter 0. The core is expected to share the same `rst`.

## Timing
- Reset values: `start`=0, `a_out`=0, `b_out`=0, `result_out`=0, `result_valid`=0, `err`=0, `phase`=00.
- Press latency: `key_n` falling at edge 0 (setup met) gives `press`=1 in cycle 2 + DEBOUNCE_CYCLES + 1 (±1 for asynchronous skew).
- Capture: `a_out`/`b_out` update on the edge that ends the `press` cycle.
- `start` is high in the cycle immediately after the B capture edge.
- `result_out` and `result_valid` update on the edge that ends the first BUSY cycle with `done`=1.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
- Holding the key produces exactly one event per press.

## Test plan
- Reset: drive `rst`=0 mid-BUSY, asynchronously -> all outputs 0 and `phase`=00 before the next clock edge; after release, state IDLE_A.
- Basic flow: `sw`=236 (8'hEC, i.e. -20), press; `sw`=50, press -> `a_out`=236, `b_out`=50, single `start` pulse. Stub core returns 2 with `done` after 10 cycles -> `result_out`=2, `result_valid`=1, `phase`=11.
- Debounce: 10-cycle low glitch on `key_n` with DEBOUNCE_CYCLES=16 -> no `press`, state unchanged. A 5 ms hold -> exactly one `press`; its arrival cycle matches the press-latency rule.
- Zero operand: A=0, B=7 -> `err`=1, `phase`=11, `start` never asserted. Next press -> IDLE_A with `err`=0.
- Ignore rules: press during BUSY, and `done` pulsed in IDLE_A and SHOW -> no state change, `result_out` unchanged.
- Second run: press in SHOW -> outputs cleared; then A=48, B=18 -> `start` asserted again, stub result 6 latched.

Source files
------------

// File: rtl/gcd_operand_loader.sv
// Operand entry stage for the GCD core: debounced key, two switch captures, start pulse,
// result latch for the LEDs. Zero operands are diverted to ERR before the core is started.
module gcd_operand_loader #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             CLOCK_125_p,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   input  logic             key_n,
   output logic             start,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   input  logic             done,
   input  logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_out,
   output logic             result_valid,
   output logic             err,
   output logic [1:0]       phase
);

   // state  | meaning
   // IDLE_A | waiting for the press that captures operand A
   // WAIT_B | A held, waiting for the press that captures operand B
   // START  | one-cycle start pulse to the core
   // BUSY   | core running, waiting for done
   // SHOW   | result latched and shown, next press returns to IDLE_A
   // ERR    | an operand was zero, next press returns to IDLE_A
   typedef enum logic [2:0] {
      S_IDLE_A = 3'd0,
      S_WAIT_B = 3'd1,
      S_START  = 3'd2,
      S_BUSY   = 3'd3,
      S_SHOW   = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic             key_s1;
   logic             key_s2;
   logic             key_lvl;
   logic             key_lvl_d;
   logic [CNT_W-1:0] db_cnt;
   logic             press;
   logic             load_a;
   logic             load_b;
   logic             load_res;
   logic             clear;

   // The counter measures the current run of cycles where the synchronized key disagrees
   // with the accepted level; any agreeing cycle restarts the run.
   always_ff @(posedge CLOCK_125_p or negedge rst) begin
      if (!rst) begin
         key_s1    <= 1'b1;
         key_s2    <= 1'b1;
         key_lvl   <= 1'b1;
         key_lvl_d <= 1'b1;
         db_cnt    <= '0;
         press     <= 1'b0;
      end else begin
         key_s1    <= key_n;
         key_s2    <= key_s1;
         key_lvl_d <= key_lvl;
         press     <= key_lvl_d & ~key_lvl;
         if (key_s2 == key_lvl) begin
            db_cnt <= '0;
         end else if (db_cnt == CNT_LAST) begin
            key_lvl <= key_s2;
            db_cnt  <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_125_p or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE_A;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      load_a       = 1'b0;
      load_b       = 1'b0;
      load_res     = 1'b0;
      clear        = 1'b0;
      start        = 1'b0;
      result_valid = 1'b0;
      err          = 1'b0;
      phase        = 2'b00;
      case (state)
         S_IDLE_A: begin
            if (press) begin
               load_a    = 1'b1;
               state_nxt = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            phase = 2'b01;
            if (press) begin
               load_b    = 1'b1;
               state_nxt = ((a_out == '0) || (sw == '0)) ? S_ERR : S_START;
            end
         end
         S_START: begin
            phase     = 2'b10;
            start     = 1'b1;
            state_nxt = S_BUSY;
         end
         S_BUSY: begin
            phase = 2'b10;
            if (done) begin
               load_res  = 1'b1;
               state_nxt = S_SHOW;
            end
         end
         S_SHOW: begin
            phase        = 2'b11;
            result_valid = 1'b1;
            if (press) begin
               clear     = 1'b1;
               state_nxt = S_IDLE_A;
            end
         end
         S_ERR: begin
            phase = 2'b11;
            err   = 1'b1;
            if (press) begin
               clear     = 1'b1;
               state_nxt = S_IDLE_A;
            end
         end
         default: begin
            state_nxt = S_IDLE_A;
         end
      endcase
   end

   // Operands stay put from START until the next return to IDLE_A so the core sees stable inputs.
   always_ff @(posedge CLOCK_125_p or negedge rst) begin
      if (!rst) begin
         a_out      <= '0;
         b_out      <= '0;
         result_out <= '0;
      end else if (clear) begin
         a_out      <= '0;
         b_out      <= '0;
         result_out <= '0;
      end else begin
         if (load_a) begin
            a_out <= sw;
         end
         if (load_b) begin
            b_out <= sw;
         end
         if (load_res) begin
            result_out <= result;
         end
      end
   end

endmodule

// File: tb/tb_gcd_operand_loader.sv
// Scoreboard bench for gcd_operand_loader: directed presses, a stub GCD core, and a monitor
// that pops the expected start/result/err events as the DUT presents them.
module tb_gcd_operand_loader;

   localparam int D = 16;
   localparam int K_START = 0;
   localparam int K_RESULT = 1;
   localparam int K_ERR = 2;

   typedef struct {
      int         kind;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] r;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sw;
   logic       key_n;
   logic       start;
   logic [7:0] a_out;
   logic [7:0] b_out;
   logic       done;
   logic [7:0] result;
   logic [7:0] result_out;
   logic       result_valid;
   logic       err;
   logic [1:0] phase;

   logic       done_stub = 1'b0;
   logic [7:0] res_stub = 8'd0;
   logic       done_man = 1'b0;
   logic [7:0] res_man = 8'd0;
   logic [7:0] stub_res = 8'd0;
   int         stub_delay = 10;

   int   checks = 0;
   int   errors = 0;
   int   start_count = 0;
   exp_t sb[$];

   assign done   = done_stub | done_man;
   assign result = done_man ? res_man : res_stub;

   always #4 clk = ~clk;

   gcd_operand_loader #(.WIDTH(8), .DEBOUNCE_CYCLES(D)) dut (
      .CLOCK_125_p (clk),
      .rst         (rst),
      .sw          (sw),
      .key_n       (key_n),
      .start       (start),
      .a_out       (a_out),
      .b_out       (b_out),
      .done        (done),
      .result      (result),
      .result_out  (result_out),
      .result_valid(result_valid),
      .err         (err),
      .phase       (phase)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push_exp(input int kind, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r);
      exp_t e;
      e.kind = kind;
      e.a    = a;
      e.b    = b;
      e.r    = r;
      sb.push_back(e);
   endtask

   task automatic press_key(input logic [7:0] v);
      @(posedge clk);
      #1 sw = v;
      key_n = 1'b0;
      repeat (D + 8) @(posedge clk);
      #1 key_n = 1'b1;
      repeat (D + 8) @(posedge clk);
   endtask

   task automatic wait_phase(input string name, input logic [1:0] p, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (phase == p) break;
      end
      chk(name, {30'd0, phase}, {30'd0, p});
   endtask

   task automatic pulse_done(input logic [7:0] v);
      @(posedge clk);
      #1 done_man = 1'b1;
      res_man = v;
      @(posedge clk);
      #1 done_man = 1'b0;
      res_man = 8'd0;
   endtask

   // Stub core: answers stub_res after stub_delay cycles, abandons the job on reset.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && start) begin
            automatic bit aborted = 1'b0;
            for (int i = 0; i < stub_delay; i++) begin
               @(posedge clk);
               if (!rst) begin
                  aborted = 1'b1;
                  break;
               end
            end
            if (!aborted) begin
               #1 done_stub = 1'b1;
               res_stub = stub_res;
               @(posedge clk);
               #1 done_stub = 1'b0;
               res_stub = 8'd0;
            end
         end
      end
   end

   initial begin
      automatic logic prev_rv = 1'b0;
      automatic logic prev_err = 1'b0;
      automatic logic prev_start = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_rv    = 1'b0;
            prev_err   = 1'b0;
            prev_start = 1'b0;
         end else begin
            if (start) begin
               start_count++;
               chk("start_single_cycle", {31'd0, prev_start}, 32'd0);
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_start unexpected start a=%0d b=%0d", a_out, b_out);
               end else begin
                  e = sb.pop_front();
                  chk("sb_start_kind", K_START, e.kind);
                  chk("sb_start_a", {24'd0, a_out}, {24'd0, e.a});
                  chk("sb_start_b", {24'd0, b_out}, {24'd0, e.b});
               end
            end
            if (result_valid && !prev_rv) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_result unexpected result=%0d", result_out);
               end else begin
                  e = sb.pop_front();
                  chk("sb_result_kind", K_RESULT, e.kind);
                  chk("sb_result_value", {24'd0, result_out}, {24'd0, e.r});
               end
            end
            if (err && !prev_err) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_err unexpected err a=%0d b=%0d", a_out, b_out);
               end else begin
                  e = sb.pop_front();
                  chk("sb_err_kind", K_ERR, e.kind);
               end
            end
            prev_rv    = result_valid;
            prev_err   = err;
            prev_start = start;
         end
      end
   end

   initial begin
      automatic int n = 0;
      rst   = 1'b0;
      key_n = 1'b1;
      sw    = 8'd0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {start, a_out, b_out, result_out, result_valid, err, phase}, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (4) @(posedge clk);

      // Short glitch must not register.
      sw = 8'd55;
      @(posedge clk);
      #1 key_n = 1'b0;
      repeat (10) @(posedge clk);
      #1 key_n = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("glitch_phase", {30'd0, phase}, 32'd0);
      chk("glitch_a", {24'd0, a_out}, 32'd0);

      // A capture with latency measurement and a long hold.
      @(posedge clk);
      #1 sw = 8'd236;
      key_n = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1 n++;
         if (phase == 2'b01) break;
      end
      checks++;
      if (n < D + 4 || n > D + 6) begin
         errors++;
         $display("FAIL press_latency actual=%0d edges required=%0d..%0d", n, D + 4, D + 6);
      end
      repeat (200) @(posedge clk);
      #1 key_n = 1'b1;
      repeat (D + 8) @(posedge clk);
      @(negedge clk);
      chk("hold_one_event_phase", {30'd0, phase}, 32'd1);
      chk("capture_a", {24'd0, a_out}, 32'd236);

      // First run: gcd(236,50)=2.
      stub_res   = 8'd2;
      stub_delay = 10;
      push_exp(K_START, 8'd236, 8'd50, 8'd0);
      push_exp(K_RESULT, 8'd0, 8'd0, 8'd2);
      press_key(8'd50);
      wait_phase("run1_show", 2'b11, 200);
      chk("run1_result", {24'd0, result_out}, 32'd2);
      chk("run1_valid", {31'd0, result_valid}, 32'd1);

      pulse_done(8'd99);
      @(negedge clk);
      chk("done_in_show_result", {24'd0, result_out}, 32'd2);
      chk("done_in_show_phase", {30'd0, phase}, 32'd3);

      press_key(8'd77);
      @(negedge clk);
      chk("clear_outputs", {start, a_out, b_out, result_out, result_valid, err, phase}, 0);
      pulse_done(8'd44);
      @(negedge clk);
      chk("done_in_idle", {22'd0, result_out, phase}, 32'd0);

      // Zero operand path.
      push_exp(K_ERR, 8'd0, 8'd0, 8'd0);
      press_key(8'd0);
      press_key(8'd7);
      @(negedge clk);
      chk("zero_err", {31'd0, err}, 32'd1);
      chk("zero_phase", {30'd0, phase}, 32'd3);
      chk("zero_b", {24'd0, b_out}, 32'd7);
      press_key(8'd5);
      @(negedge clk);
      chk("err_exit_err", {31'd0, err}, 32'd0);
      chk("err_exit_phase", {30'd0, phase}, 32'd0);

      // Second run, press while busy: gcd(48,18)=6.
      stub_res   = 8'd6;
      stub_delay = 300;
      push_exp(K_START, 8'd48, 8'd18, 8'd0);
      push_exp(K_RESULT, 8'd0, 8'd0, 8'd6);
      press_key(8'd48);
      press_key(8'd18);
      @(negedge clk);
      chk("run2_busy", {30'd0, phase}, 32'd2);
      press_key(8'd99);
      @(negedge clk);
      chk("busy_press_phase", {30'd0, phase}, 32'd2);
      chk("busy_press_ops", {16'd0, a_out, b_out}, {16'd0, 8'd48, 8'd18});
      wait_phase("run2_show", 2'b11, 400);
      chk("run2_result", {24'd0, result_out}, 32'd6);

      // Third run aborted by reset mid-BUSY.
      press_key(8'd1);
      push_exp(K_START, 8'd9, 8'd6, 8'd0);
      press_key(8'd9);
      press_key(8'd6);
      @(negedge clk);
      chk("run3_busy", {30'd0, phase}, 32'd2);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk("async_reset_outputs",
             {start, a_out, b_out, result_out, result_valid, err, phase}, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("post_reset_phase", {30'd0, phase}, 32'd0);
      repeat (350) @(posedge clk);
      @(negedge clk);
      chk("post_reset_idle", {22'd0, result_out, phase}, 32'd0);

      chk("scoreboard_drained", sb.size(), 32'd0);
      chk("start_count", start_count, 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
